// File: rtl/buffer_sched.sv
// Round-robin push arbiter and push/pop interleaver sitting in front of a shared buffer.
// Tracks occupancy itself so the buffer never sees an overflow, underflow or simultaneous op.
module buffer_sched #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          pop_req,
  output logic                          rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          buf_push_en,
  output logic                          buf_push,
  output logic                          buf_pop_en,
  output logic                          buf_pop,
  output logic [DATA_WIDTH-1:0]         buf_data_in,
  input  logic [DATA_WIDTH-1:0]         buf_data_out,
  input  logic                          buf_err,
  output logic [CW-1:0]                 count,
  output logic                          err_flag
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP} op_e;

  op_e                   op_sel;
  op_e                   last_op;
  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rr_ptr_nxt;
  logic [PW-1:0]         win_idx;
  logic                  win_found;
  logic [NUM_REQ-1:0]    masked_req;
  logic                  push_cand;
  logic                  pop_cand;
  int                    idx;

  assign rd_data = buf_data_out;

  // Decision stage: eligibility, op choice and round-robin winner
  always_comb begin
    masked_req = req & ~gnt;
    push_cand  = (|masked_req) && (count < DEPTH_C) && !err_flag;
    pop_cand   = pop_req && (count != '0) && !err_flag;

    op_sel = OP_IDLE;
    if (push_cand && pop_cand) op_sel = (last_op == OP_PUSH) ? OP_POP : OP_PUSH;
    else if (push_cand)        op_sel = OP_PUSH;
    else if (pop_cand)         op_sel = OP_POP;

    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && masked_req[idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(idx);
      end
    end

    rr_ptr_nxt = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PW'(1);
  end

  // Issue stage: buffer controls, grant, occupancy and read-valid tracking
  always_ff @(posedge clk) begin
    if (rst_n) begin
      gnt         <= '0;
      buf_push_en <= 1'b0;
      buf_push    <= 1'b0;
      buf_pop_en  <= 1'b0;
      buf_pop     <= 1'b0;
      buf_data_in <= '0;
      count       <= '0;
      err_flag    <= 1'b0;
      rd_valid    <= 1'b0;
      rr_ptr      <= '0;
      last_op     <= OP_POP;
    end else begin
      rd_valid    <= buf_pop;
      err_flag    <= err_flag | buf_err;
      gnt         <= '0;
      buf_push_en <= 1'b0;
      buf_push    <= 1'b0;
      buf_pop_en  <= 1'b0;
      buf_pop     <= 1'b0;
      case (op_sel)
        OP_PUSH: begin
          gnt         <= NUM_REQ'(1) << win_idx;
          buf_push_en <= 1'b1;
          buf_push    <= 1'b1;
          buf_data_in <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          count       <= count + CW'(1);
          rr_ptr      <= rr_ptr_nxt;
          last_op     <= OP_PUSH;
        end
        OP_POP: begin
          buf_pop_en  <= 1'b1;
          buf_pop     <= 1'b1;
          count       <= count - CW'(1);
          last_op     <= OP_POP;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/buffer_sched.md
Name: buffer_sched

Overview:
- Round-robin scheduler that shares one buffer instance between NUM_REQ producers and a single consumer.
- Arbitrates producer push requests and interleaves consumer pops. It drives the buffer's push_en/push/data_in/pop_en/pop controls so the buffer never sees an error condition.
- Tracks occupancy internally, because the buffer's is_full/is_empty lag an issued operation by one cycle.
- Sits directly in front of the buffer; the consumer reads buffer data through this block.

Parameters:
NUM_REQ, 4, number of producers (>=2)
DATA_WIDTH, 8, data word width; must match the buffer
DEPTH, 8, buffer depth; must match the buffer
CW (localparam), $clog2(DEPTH+1), occupancy counter width

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  reset, synchronous, active-high (name kept per codebase convention; 1 = reset)
req  in  NUM_REQ  per-producer push request, level
req_data  in  NUM_REQ*DATA_WIDTH  producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
gnt  out  NUM_REQ  one-hot, registered; high for the cycle that producer's word is pushed
pop_req  in  1  consumer wants one word per cycle while high
rd_valid  out  1  registered; rd_data is a valid popped word this cycle
rd_data  out  DATA_WIDTH  combinational pass-through of buf_data_out
buf_push_en, buf_push  out  1 each  to buffer push_en/push, registered
buf_pop_en, buf_pop  out  1 each  to buffer pop_en/pop, registered
buf_data_in  out  DATA_WIDTH  to buffer data_in, registered
buf_data_out  in  DATA_WIDTH  from buffer data_out
buf_err  in  1  from buffer err
count  out  CW  words held, including operations issued this cycle
err_flag  out  1  sticky; buffer reported err

Behaviour:
- Reset (rst_n=1 at posedge):
  - All outputs 0: gnt, rd_valid, buf_*, count, err_flag.
  - rr_ptr=0; last_op=POP, so the first contention favours push.
  - Reset mid-operation discards in-flight ops and clears count; the buffer must be reset in the same cycle.
- Eligibility, evaluated each cycle on current inputs and registers:
  - masked_req = req & ~gnt. A producer granted this cycle is excluded, so a held req cannot double-push.
  - push_cand = |masked_req & (count < DEPTH) & ~err_flag.
  - pop_cand = pop_req & (count > 0) & ~err_flag.
- Op select, at most one op per cycle (never push and pop together):
  - Only push_cand -> PUSH.
  - Only pop_cand -> POP.
  - Both -> opposite of last_op.
  - Neither -> IDLE.
  - last_op updates only on PUSH or POP.
- Round robin:
  - Winner = first set bit of masked_req searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - On PUSH, rr_ptr <= (winner+1) mod NUM_REQ; otherwise rr_ptr is held.
- Registered outputs at the posedge ending the decision cycle:
  - PUSH: buf_push_en=buf_push=1; buf_data_in=req_data[winner]; gnt=onehot(winner).
  - POP: buf_pop_en=buf_pop=1.
  - Otherwise all control outputs 0; buf_data_in holds its last value.
- Handshake:
  - Producer holds req and data stable until gnt is seen.
  - Producer may keep req high for back-to-back words; its next word is eligible the cycle after gnt.
- Read latency:
  - The buffer registers data_out on the edge after buf_pop, so rd_valid = buf_pop delayed by one cycle.
  - rd_valid is a one-cycle pulse per pop; the consumer samples rd_data when rd_valid=1.
- Occupancy:
  - count += 1 on PUSH and -= 1 on POP, updated together with the buf_* registers.
  - Saturation cannot occur by construction.
  - count==DEPTH blocks all grants; count==0 blocks pops.
- Error:
  - buf_err=1 sets err_flag at the next posedge; only reset clears it.
  - While err_flag=1, no ops issue: gnt=0, buf_* controls=0.
  - rd_valid still completes for a pop already issued.
- Throughput: one op per cycle. Contended push/pop alternate 1:1. NUM_REQ producers all requesting get one grant each per NUM_REQ pushes.

Test Plan:
- Reset, then req=4'b1111 with data 0x10,0x11,0x12,0x13 held and pop_req=0 -> gnt sequence 0001,0010,0100,1000,0001,... Eight pushes, count reaches 8, no gnt afterwards, buf_err never 1.
- Full buffer (count=8) with req=1111 and pop_req=1 -> first op is POP (count 7), then push/pop alternate, count toggles 7/8. rd_valid pulses one cycle after each buf_pop.
- Single producer req=4'b0100 held high for 3 words, count=0, pop_req=0 -> gnt=0100 on alternating cycles only (masked while gnt high); rr_ptr=3 afterwards; count=3.
- Push 0xA1,0xA2,0xA3 from producer 1, then pop_req=1 for 4 cycles (FIFO buffer) -> rd_data 0xA1,0xA2,0xA3 on three rd_valid pulses. Fourth cycle: no buf_pop, count=0.
- Force buf_err=1 for one cycle mid-traffic -> err_flag=1 next cycle and stays high. gnt, buf_push and buf_pop stay 0 until rst_n=1, after which all outputs are 0 and count=0.
- Assert rst_n=1 for one cycle while count=5 and req/pop_req active -> next cycle count=0, gnt=0, rd_valid=0. Round robin restarts at producer 0.
